// File: rtl/scan_decoder_if.sv
// Bus bundle for scan_decoder: control inputs and registered decode outputs.
// SCAN_DECODER_DIR_EN adds the DIR scan-direction signal.
interface scan_decoder_if #(
    parameter int SEL_W = 2,
    parameter int DIV_W = 4
);
    localparam int N = 2**SEL_W;

    logic             G_L;
    logic             MODE;
`ifdef SCAN_DECODER_DIR_EN
    logic             DIR;
`endif
    logic [SEL_W-1:0] SEL;
    logic [DIV_W-1:0] DIV;
    logic [N-1:0]     Y_L;
    logic [SEL_W-1:0] IDX;
    logic             WRAP;

    modport master (
        output G_L, MODE,
`ifdef SCAN_DECODER_DIR_EN
        DIR,
`endif
        SEL, DIV,
        input  Y_L, IDX, WRAP
    );

    modport slave (
        input  G_L, MODE,
`ifdef SCAN_DECODER_DIR_EN
        DIR,
`endif
        SEL, DIV,
        output Y_L, IDX, WRAP
    );
endinterface

// File: rtl/scan_decoder.sv
// Registered SEL_W-to-2^SEL_W active-low decoder with direct and auto-scan modes; SCAN_DECODER_DIR_EN adds down-scan via DIR.
// Latency one cycle from any input to Y_L/IDX/WRAP; no backpressure, G_L=1 blanks outputs and freezes the scan.
module scan_decoder #(
    parameter int SEL_W = 2,
    parameter int DIV_W = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    scan_decoder_if.slave bus
);
    localparam int N = 2**SEL_W;
    localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(N-1);

    logic [SEL_W-1:0] idx_q, idx_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [N-1:0]     y_q, y_d;
    logic             wrap_q, wrap_d;
    logic             step_down;

`ifdef SCAN_DECODER_DIR_EN
    assign step_down = bus.DIR;
`else
    assign step_down = 1'b0;
`endif

    always_comb begin
        idx_d   = idx_q;
        presc_d = presc_q;
        wrap_d  = 1'b0;
        y_d     = '1;
        if (!bus.G_L) begin
            if (!bus.MODE) begin
                idx_d   = bus.SEL;
                presc_d = '0;
            end else if (presc_q >= bus.DIV) begin
                // >= rather than == so a DIV lowered mid-count steps at once
                presc_d = '0;
                if (step_down) begin
                    idx_d  = idx_q - SEL_W'(1);
                    wrap_d = (idx_q == '0);
                end else begin
                    idx_d  = idx_q + SEL_W'(1);
                    wrap_d = (idx_q == IDX_MAX);
                end
            end else begin
                presc_d = presc_q + DIV_W'(1);
            end
            y_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            idx_q   <= '0;
            presc_q <= '0;
            y_q     <= '1;
            wrap_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            presc_q <= presc_d;
            y_q     <= y_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.Y_L  = y_q;
    assign bus.IDX  = idx_q;
    assign bus.WRAP = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder (SEL_W=2, DIV_W=4) with hand-computed expected outputs.
module tb_scan_decoder;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    scan_decoder_if #(.SEL_W(2), .DIV_W(4)) bus ();

    scan_decoder #(.SEL_W(2), .DIV_W(4)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare all three outputs plus the at-most-one-low invariant.
    task automatic expect_out(input string tag, input logic [3:0] y, input logic [1:0] idx, input logic wrap);
        chk({tag, ".y"}, 32'(bus.Y_L), 32'(y));
        chk({tag, ".idx"}, 32'(bus.IDX), 32'(idx));
        chk({tag, ".wrap"}, 32'(bus.WRAP), 32'(wrap));
        chk({tag, ".onehot"}, 32'($countones(~bus.Y_L) <= 1), 32'd1);
    endtask

    // Active-low one-hot code for each index, written out by hand.
    logic [3:0] y_of [4];
    logic [1:0] scan_idx [12];

    initial begin
        n_chk = 0;
        n_bad = 0;
        y_of  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        scan_idx = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};

        rst      = 1'b1;
        bus.G_L  = 1'b0;
        bus.MODE = 1'b0;
        bus.SEL  = 2'd3;
        bus.DIV  = 4'd0;
`ifdef SCAN_DECODER_DIR_EN
        bus.DIR  = 1'b0;
`endif
        tick();
        expect_out("rst0", 4'b1111, 2'd0, 1'b0);
        tick();
        expect_out("rst1", 4'b1111, 2'd0, 1'b0);
        rst = 1'b0;
        tick();
        expect_out("rel", 4'b0111, 2'd3, 1'b0);

        for (int s = 0; s < 4; s++) begin
            bus.SEL = 2'(s);
            tick();
            expect_out($sformatf("dir%0d", s), y_of[s], 2'(s), 1'b0);
        end

        // Scan from IDX=0 (loaded in the sweep's... reload explicitly) with DIV=2.
        bus.SEL = 2'd0;
        tick();
        expect_out("load0", 4'b1110, 2'd0, 1'b0);
        bus.MODE = 1'b1;
        bus.DIV  = 4'd2;
        for (int i = 0; i < 12; i++) begin
            tick();
            expect_out($sformatf("scan%0d", i), y_of[scan_idx[i]], scan_idx[i], i == 11);
        end

        // Advance to IDX=2 with prescaler=1.
        for (int i = 0; i < 7; i++) tick();
        expect_out("pre_dis", 4'b1011, 2'd2, 1'b0);
        bus.G_L = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out($sformatf("dis%0d", i), 4'b1111, 2'd2, 1'b0);
        end
        bus.G_L = 1'b0;
        tick();
        expect_out("reen0", 4'b1011, 2'd2, 1'b0);
        tick();
        expect_out("reen1", 4'b0111, 2'd3, 1'b0);

        // DIV 7 -> 1 once the prescaler has reached 5.
        bus.DIV = 4'd7;
        for (int i = 0; i < 5; i++) tick();
        expect_out("div7", 4'b0111, 2'd3, 1'b0);
        bus.DIV = 4'd1;
        tick();
        expect_out("divdn", 4'b1110, 2'd0, 1'b1);
        tick();
        expect_out("div1a", 4'b1110, 2'd0, 1'b0);
        tick();
        expect_out("div1b", 4'b1101, 2'd1, 1'b0);
        tick();
        expect_out("div1c", 4'b1101, 2'd1, 1'b0);
        tick();
        expect_out("div1d", 4'b1011, 2'd2, 1'b0);

        rst = 1'b1;
        tick();
        expect_out("rstscan", 4'b1111, 2'd0, 1'b0);
        rst = 1'b0;

        // DIV=0 scan steps every cycle, then a 1->0 mode switch loads SEL without WRAP.
        bus.DIV = 4'd0;
        tick();
        expect_out("fast0", 4'b1101, 2'd1, 1'b0);
        tick();
        expect_out("fast1", 4'b1011, 2'd2, 1'b0);
        tick();
        expect_out("fast2", 4'b0111, 2'd3, 1'b0);
        tick();
        expect_out("fast3", 4'b1110, 2'd0, 1'b1);
        bus.MODE = 1'b0;
        bus.SEL  = 2'd2;
        tick();
        expect_out("m10", 4'b1011, 2'd2, 1'b0);

`ifdef SCAN_DECODER_DIR_EN
        bus.SEL = 2'd1;
        tick();
        expect_out("dload", 4'b1101, 2'd1, 1'b0);
        bus.MODE = 1'b1;
        bus.DIR  = 1'b1;
        tick();
        expect_out("down0", 4'b1110, 2'd0, 1'b0);
        tick();
        expect_out("down1", 4'b0111, 2'd3, 1'b1);
        tick();
        expect_out("down2", 4'b1011, 2'd2, 1'b0);
        tick();
        expect_out("down3", 4'b1101, 2'd1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
